// File: rtl/relu.sv
// Registered ReLU (optionally ReLU-N) activation with a PIPE_STAGES-deep data/valid pipeline.
// Latency PIPE_STAGES cycles, one sample per clock, no back-pressure.
module relu #(
  parameter int                       DATA_W      = 16,
  parameter int                       PIPE_STAGES = 1,
  parameter int                       CLIP_EN     = 0,
  parameter logic signed [DATA_W-1:0] CLIP_MAX    = {1'b0, {(DATA_W-1){1'b1}}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] nn_input,
  input  logic                     in_valid,
  output logic signed [DATA_W-1:0] relu_output,
  output logic                     out_valid
);

  if (DATA_W < 2) begin : g_bad_width
    $error("relu: DATA_W must be at least 2");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_depth
    $error("relu: PIPE_STAGES must be within 1..4");
  end
  if (CLIP_MAX < 0) begin : g_bad_clip
    $error("relu: CLIP_MAX must be non-negative");
  end

  logic signed [DATA_W-1:0] act_d;
  logic signed [DATA_W-1:0] data_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]   vld_q;

  // Sign bit alone decides the negative case, so the most-negative input maps to 0 without overflow.
  always_comb begin
    act_d = nn_input;
    if (nn_input[DATA_W-1]) begin
      act_d = '0;
    end else if ((CLIP_EN != 0) && (nn_input > CLIP_MAX)) begin
      act_d = CLIP_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        data_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      data_q[0] <= act_d;
      vld_q[0]  <= in_valid;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign relu_output = data_q[PIPE_STAGES-1];
  assign out_valid   = vld_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_relu.sv
// Bench for relu: three instances (default, clipped at 6, three-stage pipe) share one stimulus
// stream; expected outputs come from a per-cycle input history and a max(0,x) reference.
module tb_relu;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] nn_input;
  logic               in_valid;

  logic signed [15:0] y_def, y_clp, y_p3;
  logic               v_def, v_clp, v_p3;

  int checks = 0;
  int errors = 0;

  int hist_x[$];
  bit hist_v[$];

  relu u_def (
    .clk(clk), .rst_n(rst_n), .nn_input(nn_input), .in_valid(in_valid),
    .relu_output(y_def), .out_valid(v_def)
  );

  relu #(.CLIP_EN(1), .CLIP_MAX(16'sd6)) u_clp (
    .clk(clk), .rst_n(rst_n), .nn_input(nn_input), .in_valid(in_valid),
    .relu_output(y_clp), .out_valid(v_clp)
  );

  relu #(.PIPE_STAGES(3)) u_p3 (
    .clk(clk), .rst_n(rst_n), .nn_input(nn_input), .in_valid(in_valid),
    .relu_output(y_p3), .out_valid(v_p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_relu(input int x, input bit clip, input int cmax);
    if (x < 0) return 0;
    if (clip && x > cmax) return cmax;
    return x;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected output of an instance with the given latency, from the inputs sampled since reset.
  task automatic check_inst(input string tag, input int lat, input bit clip, input int cmax,
                            input int got_y, input bit got_v);
    int  n;
    bit  ev;
    int  ex;
    n  = hist_x.size();
    ev = 1'b0;
    ex = 0;
    if (n >= lat) begin
      ev = hist_v[n-lat];
      ex = hist_x[n-lat];
    end
    check({tag, "_vld"}, int'(got_v), int'(ev));
    if (ev) check({tag, "_dat"}, got_y, ref_relu(ex, clip, cmax));
  endtask

  task automatic check_all();
    check_inst("def", 1, 1'b0, 0, int'(y_def), v_def);
    check_inst("clp", 1, 1'b1, 6, int'(y_clp), v_clp);
    check_inst("p3",  3, 1'b0, 0, int'(y_p3),  v_p3);
  endtask

  // Called at a negedge: drive, take one rising edge, record, then check at the next negedge.
  task automatic step(input int x, input bit v);
    nn_input = 16'(x);
    in_valid = v;
    @(posedge clk);
    hist_x.push_back(x);
    hist_v.push_back(v);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_def_y"}, int'(y_def), 0);
    check({tag, "_def_v"}, int'(v_def), 0);
    check({tag, "_clp_y"}, int'(y_clp), 0);
    check({tag, "_clp_v"}, int'(v_clp), 0);
    check({tag, "_p3_y"},  int'(y_p3),  0);
    check({tag, "_p3_v"},  int'(v_p3),  0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero({tag, "_now"});
    repeat (2) @(posedge clk);
    #1;
    check_all_zero({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
    hist_x.delete();
    hist_v.delete();
  endtask

  initial begin
    rst_n    = 1'b1;
    nn_input = 16'sd1234;
    in_valid = 1'b1;

    // Load non-zero state so the asynchronous clear is observable.
    repeat (4) @(posedge clk);
    nn_input = 16'sd1234;
    in_valid = 1'b1;
    do_reset("rst");

    // Boundary values
    step(32767, 1'b1);
    step(-32768, 1'b1);
    step(1234, 1'b1);
    step(-1234, 1'b1);
    step(0, 1'b1);

    // Hold at zero
    for (int i = 0; i < 5; i++) step(0, 1'b1);

    // Valid tracking
    step(500, 1'b1);
    step(700, 1'b0);
    step(-3, 1'b1);
    step(42, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 1'b0);

    // Clip sequence
    step(3, 1'b1);
    step(6, 1'b1);
    step(7, 1'b1);
    step(32767, 1'b1);
    step(-5, 1'b1);

    // Pulse through the three-stage pipe
    for (int i = 0; i < 3; i++) step(-50, 1'b1);
    step(100, 1'b1);
    for (int i = 0; i < 4; i++) step(-50, 1'b1);

    // Back-to-back sign flips
    step(32767, 1'b1);
    step(-32767, 1'b1);
    step(32767, 1'b1);
    step(-32768, 1'b1);

    // Mid-cycle input change must not reach the registered output
    nn_input = -16'sd1;
    #2;
    check("bypass_def", int'(y_def), 0);
    check("bypass_clp", int'(y_clp), 0);

    // Mid-stream reset with samples in flight
    step(111, 1'b1);
    step(222, 1'b1);
    nn_input = 16'sd333;
    in_valid = 1'b1;
    do_reset("mid");
    step(-9, 1'b0);
    step(444, 1'b1);
    step(555, 1'b1);
    step(0, 1'b0);
    step(0, 1'b0);

    // Random signed stimulus
    for (int i = 0; i < 300; i++) begin
      int x;
      x = int'($signed(16'($urandom)));
      if ($urandom_range(0, 9) == 0) x = ($urandom_range(0, 1) == 0) ? 32767 : -32768;
      step(x, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

endmodule
